// File: rtl/float_mul.sv
// float_mul: pipelined half-precision (1/5/10, bias 15) floating-point multiplier.
// Format has a hidden leading 1, no denormals and no Inf/NaN. Any operand with E=0 is zero.
// Underflow flushes to +0 and overflow saturates to the largest finite magnitude.
//
// Ports
//   clock      system clock, rising edge
//   rst        asynchronous active-high reset, clears every pipeline register
//   ce         pipeline clock enable; 0 holds every stage
//   in_valid   adata/bdata qualify this cycle (sampled only when ce=1)
//   adata      operand A {S,E,B}
//   bdata      operand B {S,E,B}
//   out_valid  cdata holds a product
//   cdata      product {S,E,B}
//
// An operand pair sampled on ce edge k is presented after ce edge k+4:
// operand latch, decode, multiply/exponent, normalise, pack.
module float_mul #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int BIAS  = 15
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     ce,
    input  logic                     in_valid,
    input  logic [EXP_W+MAN_W:0]     adata,
    input  logic [EXP_W+MAN_W:0]     bdata,
    output logic                     out_valid,
    output logic [EXP_W+MAN_W:0]     cdata
);

    localparam int DW  = 1 + EXP_W + MAN_W;
    localparam int ESW = EXP_W + 2;          // signed exponent width, holds -BIAS..2*max+1
    localparam int PW  = 2 * (MAN_W + 1);

    // Blocks capture on the first edge after reset release, even if in_valid=1 there.
    logic run_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Operand latch
    logic          v0_q;
    logic [DW-1:0] a_q, b_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            v0_q <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (ce) begin
            v0_q <= in_valid & run_q;
            a_q  <= adata;
            b_q  <= bdata;
        end
    end

    // S1: decode
    logic             v1_q, z1_q, s1_q;
    logic [EXP_W-1:0] ea1_q, eb1_q;
    logic [MAN_W-1:0] ma1_q, mb1_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            v1_q  <= 1'b0;
            z1_q  <= 1'b0;
            s1_q  <= 1'b0;
            ea1_q <= '0;
            eb1_q <= '0;
            ma1_q <= '0;
            mb1_q <= '0;
        end else if (ce) begin
            v1_q  <= v0_q;
            z1_q  <= (a_q[DW-2:MAN_W] == '0) || (b_q[DW-2:MAN_W] == '0);
            s1_q  <= a_q[DW-1] ^ b_q[DW-1];
            ea1_q <= a_q[DW-2:MAN_W];
            eb1_q <= b_q[DW-2:MAN_W];
            ma1_q <= a_q[MAN_W-1:0];
            mb1_q <= b_q[MAN_W-1:0];
        end
    end

    // S2: mantissa product and biased exponent sum
    logic                  v2_q, z2_q, s2_q;
    logic [PW-1:0]         p2_q;
    logic signed [ESW-1:0] esum2_q;
    logic [PW-1:0]         p_d;
    logic signed [ESW-1:0] esum_d;

    always_comb begin
        p_d    = {{(MAN_W + 1){1'b0}}, 1'b1, ma1_q} * {{(MAN_W + 1){1'b0}}, 1'b1, mb1_q};
        esum_d = $signed({2'b00, ea1_q}) + $signed({2'b00, eb1_q}) - $signed(ESW'(BIAS));
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            v2_q    <= 1'b0;
            z2_q    <= 1'b0;
            s2_q    <= 1'b0;
            p2_q    <= '0;
            esum2_q <= '0;
        end else if (ce) begin
            v2_q    <= v1_q;
            z2_q    <= z1_q;
            s2_q    <= s1_q;
            p2_q    <= p_d;
            esum2_q <= esum_d;
        end
    end

    // S3: normalise; product of two [1,2) values lies in [1,4), so at most one shift
    logic                  v3_q, z3_q, s3_q;
    logic [MAN_W-1:0]      man3_q;
    logic signed [ESW-1:0] e3_q;
    logic [MAN_W-1:0]      man_d;
    logic signed [ESW-1:0] e_d;

    always_comb begin
        if (p2_q[PW-1]) begin
            man_d = p2_q[PW-2:MAN_W+1];
            e_d   = esum2_q + $signed(ESW'(1));
        end else begin
            man_d = p2_q[PW-3:MAN_W];
            e_d   = esum2_q;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            v3_q   <= 1'b0;
            z3_q   <= 1'b0;
            s3_q   <= 1'b0;
            man3_q <= '0;
            e3_q   <= '0;
        end else if (ce) begin
            v3_q   <= v2_q;
            z3_q   <= z2_q;
            s3_q   <= s2_q;
            man3_q <= man_d;
            e3_q   <= e_d;
        end
    end

    // S4: pack with flush-to-zero and saturation
    logic [DW-1:0] cdata_d;
    logic          e_nonpos, e_ovf;

    always_comb begin
        e_nonpos = e3_q[ESW-1] || (e3_q == '0);
        // Once positive, any bit above the exponent field means e exceeds the largest exponent.
        e_ovf    = (e3_q[ESW-2:EXP_W] != '0);
        if (z3_q || e_nonpos) begin
            cdata_d = '0;
        end else if (e_ovf) begin
            cdata_d = {s3_q, {(DW - 1){1'b1}}};
        end else begin
            cdata_d = {s3_q, e3_q[EXP_W-1:0], man3_q};
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            cdata     <= '0;
        end else if (ce) begin
            out_valid <= v3_q;
            cdata     <= cdata_d;
        end
    end

endmodule

// File: tb/tb_float_mul.sv
module tb_float_mul;

    logic        clock = 1'b0;
    logic        rst;
    logic        ce;
    logic        in_valid;
    logic [15:0] adata;
    logic [15:0] bdata;
    logic        out_valid;
    logic [15:0] cdata;

    float_mul #(
        .EXP_W(5),
        .MAN_W(10),
        .BIAS (15)
    ) dut (
        .clock    (clock),
        .rst      (rst),
        .ce       (ce),
        .in_valid (in_valid),
        .adata    (adata),
        .bdata    (bdata),
        .out_valid(out_valid),
        .cdata    (cdata)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model straight from the number format definition.
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        int          ea, eb, e, p, m;
        logic        s;
        logic [15:0] r;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        s  = a[15] ^ b[15];
        if (ea == 0 || eb == 0) return 16'h0000;
        p = (1024 + int'(a[9:0])) * (1024 + int'(b[9:0]));
        e = ea + eb - 15;
        if (p >= (1 << 21)) begin
            m = (p >> 11) & 1023;
            e = e + 1;
        end else begin
            m = (p >> 10) & 1023;
        end
        if (e <= 0) return 16'h0000;
        if (e > 31) return {s, 15'h7FFF};
        r = {s, 5'(e), 10'(m)};
        return r;
    endfunction

    typedef struct {
        logic [15:0] exp;
        int          cnt;
    } ent_t;

    ent_t        sb[$];
    int          ce_cnt = 0;
    logic        prev_ov = 1'b0;
    logic [15:0] prev_cd = 16'h0;

    // Scoreboard push at capture, pop and compare just after the edge.
    always @(posedge clock) begin
        logic edge_ce;
        logic edge_rst;
        ent_t e;
        edge_ce  = ce;
        edge_rst = rst;
        if (edge_ce && !edge_rst) begin
            ce_cnt++;
            if (in_valid) sb.push_back('{exp: ref_mul(adata, bdata), cnt: ce_cnt});
        end
        #1;
        if (!edge_rst && !rst) begin
            if (!edge_ce) begin
                check("hold_valid", {15'b0, out_valid}, {15'b0, prev_ov});
                check("hold_cdata", cdata, prev_cd);
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", {15'b0, out_valid}, 16'h0);
                end else begin
                    e = sb.pop_front();
                    check("cdata", cdata, e.exp);
                    check("latency", 16'(ce_cnt - e.cnt), 16'd4);
                end
            end
        end
        prev_ov = out_valid;
        prev_cd = cdata;
    end

    task automatic drive(input logic [15:0] a, input logic [15:0] b);
        @(negedge clock);
        in_valid = 1'b1;
        adata    = a;
        bdata    = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        idle(1);
        while (sb.size() != 0 && t < 50) begin
            @(negedge clock);
            t++;
        end
        check("drain", 16'(sb.size()), 16'd0);
        idle(2);
    endtask

    logic [15:0] va[12] = '{16'h4000, 16'hBE00, 16'h3E00, 16'h0000, 16'h0123, 16'h8000,
                            16'h0400, 16'h7C00, 16'hFC00, 16'h3555, 16'hC1F0, 16'h2001};
    logic [15:0] vb[12] = '{16'h4200, 16'h4000, 16'h3E00, 16'h7BFF, 16'h4000, 16'hC000,
                            16'h0400, 16'h7C00, 16'h7C00, 16'h4AAA, 16'h3C01, 16'h1FFF};

    initial begin
        rst      = 1'b1;
        ce       = 1'b1;
        in_valid = 1'b0;
        adata    = 16'h0;
        bdata    = 16'h0;
        #12;
        check("rst_valid", {15'b0, out_valid}, 16'h0);
        check("rst_cdata", cdata, 16'h0);
        rst = 1'b0;
        idle(2);

        // Constant spot checks against hand-computed products.
        check("ref_1x1", ref_mul(16'h3C00, 16'h3C00), 16'h3C00);
        check("ref_2x3", ref_mul(16'h4000, 16'h4200), 16'h4600);
        check("ref_15x15", ref_mul(16'h3E00, 16'h3E00), 16'h4080);
        check("ref_ovf", ref_mul(16'hFC00, 16'h7C00), 16'hFFFF);

        // Single transaction: 1.0 * 1.0
        drive(16'h3C00, 16'h3C00);
        drain();

        // Directed corner pairs, back to back
        for (int i = 0; i < 12; i++) drive(va[i], vb[i]);
        drain();

        // Streaming: 8 pairs, 2-cycle stall after pair 4, one-cycle gap after pair 6
        for (int i = 0; i < 8; i++) begin
            drive(va[i] ^ 16'(i * 37), vb[(i + 3) % 12]);
            if (i == 3) begin
                @(negedge clock);
                ce       = 1'b0;
                in_valid = 1'b1;
                adata    = 16'hDEAD;
                bdata    = 16'hBEEF;
                @(negedge clock);
                @(negedge clock);
                ce = 1'b1;
                in_valid = 1'b0;
            end
            if (i == 5) idle(1);
        end
        drain();

        // Random stream with occasional stalls
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            ce       = ($urandom_range(0, 4) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            adata    = 16'($urandom);
            bdata    = 16'($urandom);
        end
        @(negedge clock);
        ce = 1'b1;
        drain();

        // Reset with three products in flight
        drive(16'h4000, 16'h4000);
        drive(16'h4200, 16'h3C00);
        drive(16'hC400, 16'h3E00);
        @(negedge clock);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", {15'b0, out_valid}, 16'h0);
        check("midrst_cdata", cdata, 16'h0);
        sb.delete();
        @(posedge clock);
        #3;
        rst = 1'b0;
        idle(2);
        drive(16'h4000, 16'h4200);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
